// File: rtl/replica_alu.sv
// rtl/replica_alu.sv - replica of the ALU adder critical path for on-chip timing monitoring
//
// Purpose:
//   A launch flop drives one operand bit of a WIDTH-stage ripple-carry chain.
//   The other operand is all ones, so a 1 on the launch flop ripples the
//   carry through every stage. A capture flop on the same clock samples the
//   final carry. Functionally Y is A delayed by two clock edges. Physically
//   the path from launch to capture matches the real adder's worst-case
//   carry path.
//
// Parameters:
//   WIDTH      - number of full-adder stages in the chain (2..64)
//   KEEP_CHAIN - 1: each stage's nets carry keep/dont_touch so the chain survives synthesis
//
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_ni - synchronous active-low reset
//   A      - launch stimulus from the timing monitor
//   Y      - registered carry-out of the replica chain
module replica_alu #(
  parameter int WIDTH      = 32,
  parameter int KEEP_CHAIN = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic A,
  output logic Y
);

  logic             r_launch_q;
  logic             r_capture_q;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;

  assign w_op_a     = '1;
  assign w_op_b     = {{(WIDTH-1){1'b0}}, r_launch_q};
  assign w_carry[0] = 1'b0;

  // One explicit full-adder cell per stage. No '+' is used, so the tool
  // cannot swap in a faster adder architecture.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      if (KEEP_CHAIN != 0) begin : g_keep
        (* keep = "true", dont_touch = "true" *) logic w_s;
        (* keep = "true", dont_touch = "true" *) logic w_c;
        assign w_s = w_op_a[i] ^ w_op_b[i] ^ w_carry[i];
        assign w_c = (w_op_a[i] & w_op_b[i]) | (w_carry[i] & (w_op_a[i] ^ w_op_b[i]));
        assign w_sum[i]     = w_s;
        assign w_carry[i+1] = w_c;
      end else begin : g_plain
        assign w_sum[i]     = w_op_a[i] ^ w_op_b[i] ^ w_carry[i];
        assign w_carry[i+1] = (w_op_a[i] & w_op_b[i]) | (w_carry[i] & (w_op_a[i] ^ w_op_b[i]));
      end
    end
  endgenerate

  // The sum bits have no functional consumer. They exist only so each
  // stage carries the same load as in the real ALU. This reduction marks
  // them as intentionally unobserved.
  logic w_unused_sum;
  assign w_unused_sum = ^w_sum;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_launch_q  <= 1'b0;
      r_capture_q <= 1'b0;
    end else begin
      r_launch_q  <= A;
      r_capture_q <= w_carry[WIDTH];
    end
  end

  assign Y = r_capture_q;

endmodule

// File: tb/tb_replica_alu.sv
// tb/tb_replica_alu.sv - self-checking bench for replica_alu at WIDTH 32, 4 and 64
module tb_replica_alu;

  typedef struct {
    logic rst_n;
    logic a;
    logic y;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a     = 1'b0;
  logic y32, y4, y64;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: the inputs seen at the previous rising edge.
  logic m_prev_rst = 1'b0;
  logic m_prev_a   = 1'b0;

  vec_t tbl[$];

  replica_alu #(.WIDTH(32), .KEEP_CHAIN(1)) u_w32 (.clk_i(clk), .rst_ni(rst_n), .A(a), .Y(y32));
  replica_alu #(.WIDTH(4),  .KEEP_CHAIN(0)) u_w4  (.clk_i(clk), .rst_ni(rst_n), .A(a), .Y(y4));
  replica_alu #(.WIDTH(64), .KEEP_CHAIN(1)) u_w64 (.clk_i(clk), .rst_ni(rst_n), .A(a), .Y(y64));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sum_exp(input logic launch, input int w);
    logic [63:0] ones;
    ones = {64{1'b1}};
    return launch ? 64'd0 : (ones >> (64 - w));
  endfunction

  // Drive one cycle of inputs and, optionally, a mid-cycle glitch on A that
  // settles back before the edge. Then check Y and the chain's sum bits
  // just after the edge.
  task automatic cycle(input string tag, input logic r, input logic av,
                       input logic exp_y, input bit glitch);
    logic launch;
    rst_n = r;
    a     = av;
    if (glitch) begin
      #2 a = ~av;
      #1 a = av;
    end
    @(posedge clk);
    #1;
    launch = r & av;
    cmp({tag, " y32"}, {63'd0, y32}, {63'd0, exp_y});
    cmp({tag, " y4"},  {63'd0, y4},  {63'd0, exp_y});
    cmp({tag, " y64"}, {63'd0, y64}, {63'd0, exp_y});
    cmp({tag, " sum32"}, {32'd0, u_w32.w_sum}, sum_exp(launch, 32));
    cmp({tag, " sum4"},  {60'd0, u_w4.w_sum},  sum_exp(launch, 4));
    cmp({tag, " sum64"}, u_w64.w_sum,          sum_exp(launch, 64));
    m_prev_rst = r;
    m_prev_a   = av;
  endtask

  function automatic void push(input logic r, input logic av, input logic y);
    vec_t v;
    v.rst_n = r;
    v.a     = av;
    v.y     = y;
    tbl.push_back(v);
  endfunction

  initial begin
    // Reset held two cycles with A=1, then release.
    push(1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b0);
    // Step: ten cycles of A=0, then A=1 held. Y rises on the 2nd edge.
    for (int i = 0; i < 10; i++) push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 1'b1);
    // Return to 0. Y follows one edge later.
    push(1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    // Single-cycle pulse.
    push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    // Toggle 0,1,0,1... for 16 cycles. The previous A was 0.
    for (int i = 0; i < 16; i++) push(1'b1, logic'(i & 1), (i == 0) ? 1'b0 : logic'((i - 1) & 1));
    // Reset mid-flight: A=1 launched, then reset. Y must never show it.
    push(1'b1, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    // Reset lasting one cycle right after a launch, then recovery.
    push(1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0);

    foreach (tbl[k]) begin
      cycle($sformatf("tbl[%0d]", k), tbl[k].rst_n, tbl[k].a, tbl[k].y, 1'b0);
    end

    // Random phase. Expected Y is A from the previous edge, but only if
    // neither the previous edge nor this edge was in reset.
    for (int k = 0; k < 300; k++) begin
      logic r;
      logic av;
      logic exp_y;
      r     = ($urandom_range(0, 15) != 0);
      av    = logic'($urandom_range(0, 1));
      exp_y = (r && m_prev_rst) ? m_prev_a : 1'b0;
      cycle($sformatf("rnd[%0d]", k), r, av, exp_y, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
